wb_adder_sequencer: RTL

Wishbone master that runs operand jobs through the memory-mapped 8-bit adder peripheral. A job is two 8-bit operands offered on a valid/ready input port. The block writes the operands to the peripheral's input register, reads back the sum from its output register, and returns the sum on a valid/ready output port. It sits between a job producer (core glue or test logic) and the adder slave on the user-area Wishbone bus, and includes an ack timeout so a missing slave cannot hang the producer.

---
 rtl/wb_adder_sequencer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/wb_adder_sequencer.sv
// Wishbone master that sequences operand jobs through a memory-mapped 8-bit adder:
// write {b,a}, read back the sum, return it on a valid/ready port, with an ack timeout.
module wb_adder_sequencer #(
   parameter logic [31:0] INPUT_ADDRESS  = 32'h3000_0000,
   parameter logic [31:0] OUTPUT_ADDRESS = 32'h3000_0004,
   parameter int unsigned TIMEOUT        = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        s_valid,
   output logic        s_ready,
   input  logic [7:0]  s_a,
   input  logic [7:0]  s_b,
   output logic        m_valid,
   input  logic        m_ready,
   output logic [7:0]  m_sum,
   output logic        m_err,
   output logic        o_wb_cyc,
   output logic        o_wb_stb,
   output logic        o_wb_we,
   output logic [31:0] o_wb_addr,
   output logic [31:0] o_wb_data,
   input  logic        i_wb_ack,
   input  logic        i_wb_stall,
   input  logic [31:0] i_wb_data,
   output logic [15:0] o_done_count
);

   typedef enum logic [2:0] {
      IDLE,
      WR_REQ,
      WR_WAIT,
      RD_REQ,
      RD_WAIT,
      RESP
   } state_t;

   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

   state_t     state;
   state_t     next_state;
   logic [7:0] wait_cnt;
   logic       accept;
   logic       finish_ok;
   logic       finish_err;
   logic       timed_out;

   assign timed_out = (wait_cnt == TIMEOUT_LAST);

   // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      next_state = state;
      accept     = 1'b0;
      finish_ok  = 1'b0;
      finish_err = 1'b0;
      unique case (state)
         IDLE: begin
            if (s_valid) begin
               accept     = 1'b1;
               next_state = WR_REQ;
            end
         end
         WR_REQ: begin
            if (!i_wb_stall) begin
               next_state = WR_WAIT;
            end else if (timed_out) begin
               finish_err = 1'b1;
               next_state = RESP;
            end
         end
         WR_WAIT: begin
            if (i_wb_ack) begin
               next_state = RD_REQ;
            end else if (timed_out) begin
               finish_err = 1'b1;
               next_state = RESP;
            end
         end
         RD_REQ: begin
            if (!i_wb_stall) begin
               next_state = RD_WAIT;
            end else if (timed_out) begin
               finish_err = 1'b1;
               next_state = RESP;
            end
         end
         RD_WAIT: begin
            // A late ack on the timeout edge still wins: the job completes normally.
            if (i_wb_ack) begin
               finish_ok  = 1'b1;
               next_state = RESP;
            end else if (timed_out) begin
               finish_err = 1'b1;
               next_state = RESP;
            end
         end
         RESP: begin
            if (m_ready) begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments; reset is asynchronous and active-low.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         wait_cnt     <= 8'd0;
         m_sum        <= 8'd0;
         m_err        <= 1'b0;
         o_wb_data    <= 32'd0;
         o_done_count <= 16'd0;
      end else begin
         state <= next_state;
         if (next_state != state) begin
            wait_cnt <= 8'd0;
         end else if (o_wb_cyc) begin
            wait_cnt <= wait_cnt + 8'd1;
         end
         if (accept) begin
            o_wb_data <= {16'b0, s_b, s_a};
         end
         if (finish_ok) begin
            m_sum        <= i_wb_data[7:0];
            m_err        <= 1'b0;
            o_done_count <= o_done_count + 16'd1;
         end else if (finish_err) begin
            m_sum <= 8'd0;
            m_err <= 1'b1;
         end
      end
   end

   assign s_ready  = (state == IDLE);
   assign m_valid  = (state == RESP);
   assign o_wb_cyc = (state == WR_REQ) || (state == WR_WAIT) ||
                     (state == RD_REQ) || (state == RD_WAIT);
   assign o_wb_stb = (state == WR_REQ) || (state == RD_REQ);
   assign o_wb_we  = (state == WR_REQ);

   always_comb begin
      unique case (state)
         WR_REQ, WR_WAIT: o_wb_addr = INPUT_ADDRESS;
         RD_REQ, RD_WAIT: o_wb_addr = OUTPUT_ADDRESS;
         default:         o_wb_addr = 32'd0;
      endcase
   end

endmodule
